// File: rtl/pwr_merge_pkg.sv
// pwr_merge_pkg: shared defaults and source encoding for the dual-path merge
package pwr_merge_pkg;
  localparam int DATA_W = 8;
  localparam int SLOW_DEPTH = 4;
  localparam int STARVE_MAX = 3;
  typedef enum logic {SRC_FAST = 1'b0, SRC_SLOW = 1'b1} src_e;
endpackage

// File: rtl/pwr_edge_slow_fifo.sv
// pwr_edge_slow_fifo: slow-path buffer with extra pointer bit for full/empty
module pwr_edge_slow_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_ptr, rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic do_push, do_pop;
  assign full = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
  assign empty = wr_ptr == rd_ptr;
  assign head = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  // storage carries no reset; validity is tracked by the pointers alone
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  // pointers wrap naturally; the top bit tells full from empty
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
endmodule

// File: rtl/pwr_edge_dual_path_merge.sv
// pwr_edge_dual_path_merge: merges a bypass fast path and a buffered slow path with starvation guard
module pwr_edge_dual_path_merge #(
  parameter int DATA_W = pwr_merge_pkg::DATA_W,
  parameter int SLOW_DEPTH = pwr_merge_pkg::SLOW_DEPTH,
  parameter int STARVE_MAX = pwr_merge_pkg::STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fast_valid,
  input  logic [DATA_W-1:0] fast_data,
  output logic              fast_ready,
  input  logic              slow_valid,
  input  logic [DATA_W-1:0] slow_data,
  output logic              slow_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src,
  input  logic              out_ready,
  output logic              slow_clk_en
);
  import pwr_merge_pkg::*;
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_cnt;
  logic fifo_full, fifo_empty, load_en, force_slow, fast_win, slow_win;
  logic [DATA_W-1:0] fifo_head;
  src_e nxt_src;
  assign load_en = !out_valid || out_ready;
  assign force_slow = (starve_cnt == SW'(STARVE_MAX)) && !fifo_empty;
  assign fast_win = fast_valid && !force_slow;
  assign slow_win = !fast_win && !fifo_empty;
  assign nxt_src = slow_win ? SRC_SLOW : SRC_FAST;
  assign fast_ready = rst_n && load_en && !force_slow;
  assign slow_ready = rst_n && !fifo_full;
  assign slow_clk_en = !fifo_empty || slow_valid;
  pwr_edge_slow_fifo #(.DATA_W(DATA_W), .DEPTH(SLOW_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(slow_valid && slow_ready),
    .push_data(slow_data),
    .pop(load_en && slow_win),
    .full(fifo_full),
    .empty(fifo_empty),
    .head(fifo_head)
  );
  // output register: reloads whenever empty or drained, else holds
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_src <= 1'b0;
    end else if (load_en) begin
      out_valid <= fast_win || slow_win;
      out_data <= fast_win ? fast_data : slow_win ? fifo_head : out_data;
      out_src <= (fast_win || slow_win) ? nxt_src : out_src;
    end
  // counts fast wins while slow data waits; clears once slow is served or nothing waits
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) starve_cnt <= '0;
    else if (fifo_empty || (load_en && slow_win)) starve_cnt <= '0;
    else if (load_en && fast_win) starve_cnt <= (starve_cnt == SW'(STARVE_MAX)) ? starve_cnt : starve_cnt + 1'b1;
endmodule

// File: tb/tb_pwr_edge_dual_path_merge.sv
// tb_pwr_edge_dual_path_merge: directed vector table plus backpressure and reset sequences
module tb_pwr_edge_dual_path_merge;
  logic clk = 1'b0, rst_n = 1'b0;
  logic fast_valid = 1'b0, slow_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] fast_data = '0, slow_data = '0;
  logic fast_ready, slow_ready, out_valid, out_src, slow_clk_en;
  logic [7:0] out_data;
  int n_chk = 0, n_fail = 0;

  typedef struct {
    logic fv; logic [7:0] fd; logic sv; logic [7:0] sd; logic ordy;
    logic fr; logic sr; logic ce; logic ov; logic [7:0] od; logic os;
  } vec_t;
  vec_t v[$];

  always #5 clk = ~clk;

  pwr_edge_dual_path_merge dut (
    .clk(clk), .rst_n(rst_n),
    .fast_valid(fast_valid), .fast_data(fast_data), .fast_ready(fast_ready),
    .slow_valid(slow_valid), .slow_data(slow_data), .slow_ready(slow_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready), .slow_clk_en(slow_clk_en)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic fv, input logic [7:0] fd, input logic sv, input logic [7:0] sd,
                     input logic ordy, input logic fr, input logic sr, input logic ce,
                     input logic ov, input logic [7:0] od, input logic os);
    v.push_back('{fv, fd, sv, sd, ordy, fr, sr, ce, ov, od, os});
  endtask

  initial begin
    for (int i = 0; i < 10; i++) add(0, 8'h00, 0, 8'h00, 1, 1, 1, 0, 0, 8'h00, 0);
    for (int k = 0; k < 5; k++) add(1, 8'h10 + 8'(k), 0, 8'h00, 1, 1, 1, 0, 1, 8'h10 + 8'(k), 0);
    add(0, 8'h00, 0, 8'h00, 1, 1, 1, 0, 0, 8'h00, 0);
    add(0, 8'h00, 1, 8'hA0, 1, 1, 1, 1, 0, 8'h00, 0);
    add(0, 8'h00, 0, 8'h00, 1, 1, 1, 1, 1, 8'hA0, 1);
    add(0, 8'h00, 0, 8'h00, 1, 1, 1, 0, 0, 8'h00, 0);
    add(0, 8'h00, 1, 8'hB0, 1, 1, 1, 1, 0, 8'h00, 0);
    add(1, 8'h20, 0, 8'h00, 1, 1, 1, 1, 1, 8'h20, 0);
    add(1, 8'h21, 0, 8'h00, 1, 1, 1, 1, 1, 8'h21, 0);
    add(1, 8'h22, 0, 8'h00, 1, 1, 1, 1, 1, 8'h22, 0);
    add(1, 8'h23, 0, 8'h00, 1, 0, 1, 1, 1, 8'hB0, 1);
    add(1, 8'h23, 0, 8'h00, 1, 1, 1, 0, 1, 8'h23, 0);
    add(0, 8'h00, 0, 8'h00, 1, 1, 1, 0, 0, 8'h00, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_src", out_src, 0);
    chk("rst_fast_ready", fast_ready, 0);
    chk("rst_slow_ready", slow_ready, 0);
    chk("rst_clk_en", slow_clk_en, 0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < v.size(); i++) begin
      @(negedge clk);
      fast_valid = v[i].fv; fast_data = v[i].fd;
      slow_valid = v[i].sv; slow_data = v[i].sd; out_ready = v[i].ordy;
      #1;
      chk($sformatf("vec%0d_fast_ready", i), fast_ready, v[i].fr);
      chk($sformatf("vec%0d_slow_ready", i), slow_ready, v[i].sr);
      chk($sformatf("vec%0d_clk_en", i), slow_clk_en, v[i].ce);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_out_valid", i), out_valid, v[i].ov);
      if (v[i].ov) begin
        chk($sformatf("vec%0d_out_data", i), out_data, v[i].od);
        chk($sformatf("vec%0d_out_src", i), out_src, v[i].os);
      end
    end

    // backpressure: one word parks in the output register, four fill the FIFO
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      fast_valid = 0; out_ready = 0; slow_valid = 1; slow_data = 8'hC0 + 8'(i);
      #1 chk($sformatf("bp_push%0d_ready", i), slow_ready, 1);
      @(posedge clk);
    end
    @(negedge clk);
    slow_data = 8'hC9;
    #1;
    chk("bp_full_ready", slow_ready, 0);
    chk("bp_fast_ready", fast_ready, 0);
    chk("bp_hold_valid", out_valid, 1);
    chk("bp_hold_data", out_data, 8'hC0);
    @(posedge clk);
    #1 chk("bp_still_hold", out_data, 8'hC0);
    @(negedge clk);
    slow_valid = 0; out_ready = 1;
    for (int i = 1; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp_drain%0d_valid", i), out_valid, 1);
      chk($sformatf("bp_drain%0d_data", i), out_data, 8'hC0 + 8'(i));
      chk($sformatf("bp_drain%0d_src", i), out_src, 1);
    end
    @(posedge clk);
    #1 chk("bp_drained", out_valid, 0);

    // reset mid-operation with two FIFO entries and a held output
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      out_ready = 0; slow_valid = 1; slow_data = 8'hD0 + 8'(i);
      @(posedge clk);
    end
    @(negedge clk);
    slow_valid = 0;
    #1;
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_clk_en", slow_clk_en, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_src", out_src, 0);
    chk("mid_rst_clk_en", slow_clk_en, 0);
    chk("mid_rst_slow_ready", slow_ready, 0);
    fast_valid = 1; fast_data = 8'h55; out_ready = 1;
    #1 chk("mid_rst_fast_ready", fast_ready, 0);
    @(posedge clk);
    #1 chk("in_rst_no_load", out_valid, 0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("post_rst_fast_ready", fast_ready, 1);
    @(posedge clk);
    #1;
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_data", out_data, 8'h55);
    chk("post_rst_src", out_src, 0);
    @(negedge clk) fast_valid = 0;
    @(posedge clk);
    #1;
    chk("post_rst_fifo_empty", out_valid, 0);
    chk("post_rst_clk_en", slow_clk_en, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
